// File: rtl/sa_pkg.sv
// Shared definitions for the systolic array scheduler and the PE wrapper.
package sa_pkg;

  localparam int unsigned DefaultArraySize = 4;
  localparam int unsigned DefaultKMax      = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDone
  } state_e;

  // Row-major flat PE index, PE(0,0) at the top-left.
  function automatic int unsigned pe_index(input int unsigned i, input int unsigned j,
                                           input int unsigned n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/skew_window.sv
// Skewed operand window for one array row or column: valid while offset <= t < offset+k.
module skew_window #(
  parameter int unsigned TW = 5,
  parameter int unsigned KW = 5,
  parameter int unsigned AW = 4
) (
  input  logic          en,
  input  logic [TW-1:0] t,
  input  logic [TW-1:0] offset,
  input  logic [KW-1:0] k,
  output logic          valid,
  output logic [AW-1:0] addr
);

  logic [TW-1:0] win_end;

  // Exclusive end of the window; t is wide enough that this never overflows.
  assign win_end = offset + TW'(k);
  assign valid   = en && (t >= offset) && (t < win_end);

  always_comb begin
    addr = '0;
    if (valid) begin
      addr = AW'(t - offset);
    end
  end

endmodule

// File: rtl/systolic_array_scheduler.sv
// Start/done sequencer for one output-stationary pass: skewed operand reads and per-PE finish.
module systolic_array_scheduler
  import sa_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = DefaultArraySize,
  parameter int unsigned K_MAX      = DefaultKMax,
  parameter int unsigned AW         = $clog2(K_MAX)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(K_MAX+1)-1:0]       k_len,
  output logic                             busy,
  output logic                             done,
  output logic [ARRAY_SIZE-1:0]            a_valid,
  output logic [ARRAY_SIZE*AW-1:0]         a_addr,
  output logic [ARRAY_SIZE-1:0]            b_valid,
  output logic [ARRAY_SIZE*AW-1:0]         b_addr,
  output logic [ARRAY_SIZE*ARRAY_SIZE-1:0] finish
);

  localparam int unsigned N  = ARRAY_SIZE;
  localparam int unsigned KW = $clog2(K_MAX + 1);
  localparam int unsigned TW = $clog2(2 * N + K_MAX);

  state_e        state_q;
  logic [TW-1:0] t_q;
  logic [KW-1:0] k_q;
  logic          busy_q;
  logic          done_q;

  logic          feed;
  logic          k_ok;
  logic [TW-1:0] last_t;

  assign feed   = (state_q == StFeed);
  assign k_ok   = (k_len != '0) && (k_len <= KW'(K_MAX));
  assign last_t = TW'(2 * N - 2) + TW'(k_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start && k_ok) begin
            state_q <= StFeed;
            k_q     <= k_len;
            t_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        StFeed: begin
          if (t_q == last_t) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_window #(
      .TW(TW),
      .KW(KW),
      .AW(AW)
    ) u_a_win (
      .en    (feed),
      .t     (t_q),
      .offset(TW'(i)),
      .k     (k_q),
      .valid (a_valid[i]),
      .addr  (a_addr[i*AW +: AW])
    );

    skew_window #(
      .TW(TW),
      .KW(KW),
      .AW(AW)
    ) u_b_win (
      .en    (feed),
      .t     (t_q),
      .offset(TW'(i)),
      .k     (k_q),
      .valid (b_valid[i]),
      .addr  (b_addr[i*AW +: AW])
    );
  end

  // PE(i,j) sees its last operand pair at t = i+j+K-1, so it finishes one cycle later.
  for (genvar i = 0; i < N; i++) begin : g_fin_row
    for (genvar j = 0; j < N; j++) begin : g_fin_col
      assign finish[pe_index(i, j, N)] = feed && (t_q == TW'(i + j) + TW'(k_q));
    end
  end

endmodule

// File: tb/tb_systolic_array_scheduler.sv
// Directed bench for systolic_array_scheduler with N=4, K_MAX=16.
module tb_systolic_array_scheduler;

  localparam int N  = 4;
  localparam int KM = 16;
  localparam int AW = 4;

  logic            clk;
  logic            rst;
  logic            start;
  logic [4:0]      k_len;
  logic            busy;
  logic            done;
  logic [N-1:0]    a_valid;
  logic [N*AW-1:0] a_addr;
  logic [N-1:0]    b_valid;
  logic [N*AW-1:0] b_addr;
  logic [N*N-1:0]  finish;

  int tests_run;
  int tests_failed;

  logic            rec_busy    [0:63];
  logic            rec_done    [0:63];
  logic [N-1:0]    rec_a_valid [0:63];
  logic [N*AW-1:0] rec_a_addr  [0:63];
  logic [N*AW-1:0] rec_b_addr  [0:63];
  logic [N*N-1:0]  rec_finish  [0:63];

  systolic_array_scheduler #(
    .ARRAY_SIZE(N),
    .K_MAX     (KM),
    .AW        (AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .k_len  (k_len),
    .busy   (busy),
    .done   (done),
    .a_valid(a_valid),
    .a_addr (a_addr),
    .b_valid(b_valid),
    .b_addr (b_addr),
    .finish (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one pass with depth k and checks every cycle from t=0 through the idle cycle after done.
  task automatic run_pass(input int k, input bit hold);
    int           l;
    int           cnt [N*N];
    logic         e_feed;
    logic [N-1:0] e_v;
    logic [N*AW-1:0] e_a;
    logic [N*N-1:0]  e_f;
    logic [N*N-1:0]  once;
    l = 2 * N - 1 + k;
    for (int p = 0; p < N * N; p++) cnt[p] = 0;
    @(negedge clk);
    start = 1'b1;
    k_len = 5'(k);
    @(negedge clk);
    start = hold;
    for (int c = 0; c <= l; c++) begin
      e_feed = (c <= l - 1);
      e_v = '0;
      e_a = '0;
      e_f = '0;
      for (int i = 0; i < N; i++) begin
        if (e_feed && c >= i && c <= i + k - 1) begin
          e_v[i] = 1'b1;
          e_a[i*AW +: AW] = 4'(c - i);
        end
        for (int j = 0; j < N; j++) begin
          if (e_feed && c == i + j + k) e_f[i*N+j] = 1'b1;
        end
      end
      rec_busy[c]    = busy;
      rec_done[c]    = done;
      rec_a_valid[c] = a_valid;
      rec_a_addr[c]  = a_addr;
      rec_b_addr[c]  = b_addr;
      rec_finish[c]  = finish;
      for (int p = 0; p < N * N; p++) if (finish[p]) cnt[p]++;
      check_eq($sformatf("k%0d c%0d busy", k, c), 64'(busy), 64'(e_feed));
      check_eq($sformatf("k%0d c%0d done", k, c), 64'(done), 64'(c == l));
      check_eq($sformatf("k%0d c%0d a_valid", k, c), 64'(a_valid), 64'(e_v));
      check_eq($sformatf("k%0d c%0d a_addr", k, c), 64'(a_addr), 64'(e_a));
      check_eq($sformatf("k%0d c%0d b_valid", k, c), 64'(b_valid), 64'(e_v));
      check_eq($sformatf("k%0d c%0d b_addr", k, c), 64'(b_addr), 64'(e_a));
      check_eq($sformatf("k%0d c%0d finish", k, c), 64'(finish), 64'(e_f));
      @(negedge clk);
    end
    for (int p = 0; p < N * N; p++) once[p] = (cnt[p] == 1);
    check_eq($sformatf("k%0d finish_once", k), 64'(once), 64'hFFFF);
    check_eq($sformatf("k%0d idle_busy", k), 64'(busy), 64'd0);
    check_eq($sformatf("k%0d idle_done", k), 64'(done), 64'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    start = 1'b0;
    k_len = '0;
    repeat (3) @(negedge clk);
    check_eq("rst busy", 64'(busy), 64'd0);
    check_eq("rst done", 64'(done), 64'd0);
    check_eq("rst a_valid", 64'(a_valid), 64'd0);
    check_eq("rst a_addr", 64'(a_addr), 64'd0);
    check_eq("rst b_addr", 64'(b_addr), 64'd0);
    check_eq("rst finish", 64'(finish), 64'd0);
    rst = 1'b0;

    // K=4 pass with hand-computed landmarks
    run_pass(4, 1'b0);
    check_eq("t1 busy t0", 64'(rec_busy[0]), 64'd1);
    check_eq("t1 busy t10", 64'(rec_busy[10]), 64'd1);
    check_eq("t1 busy t11", 64'(rec_busy[11]), 64'd0);
    check_eq("t1 done t11", 64'(rec_done[11]), 64'd1);
    check_eq("t1 done t10", 64'(rec_done[10]), 64'd0);
    check_eq("t1 a_addr0 t3", 64'(rec_a_addr[3][3:0]), 64'd3);
    check_eq("t1 a_valid0 t4", 64'(rec_a_valid[4][0]), 64'd0);
    check_eq("t1 a_valid3 t2", 64'(rec_a_valid[2][3]), 64'd0);
    check_eq("t1 a_valid3 t3", 64'(rec_a_valid[3][3]), 64'd1);
    check_eq("t1 a_valid3 t6", 64'(rec_a_valid[6][3]), 64'd1);
    check_eq("t1 a_valid3 t7", 64'(rec_a_valid[7][3]), 64'd0);
    check_eq("t2 finish t4", 64'(rec_finish[4]), 64'h0001);
    check_eq("t2 finish t5", 64'(rec_finish[5]), 64'h0012);
    check_eq("t2 finish t10", 64'(rec_finish[10]), 64'h8000);
    check_eq("t2 finish t3", 64'(rec_finish[3]), 64'h0000);

    run_pass(1, 1'b0);
    check_eq("k1 a_valid2 t2", 64'(rec_a_valid[2][2]), 64'd1);
    check_eq("k1 a_addr2 t2", 64'(rec_a_addr[2][11:8]), 64'd0);
    check_eq("k1 a_valid2 t1", 64'(rec_a_valid[1][2]), 64'd0);
    check_eq("k1 a_valid2 t3", 64'(rec_a_valid[3][2]), 64'd0);
    check_eq("k1 done t8", 64'(rec_done[8]), 64'd1);

    run_pass(16, 1'b0);
    check_eq("k16 b_addr0 t15", 64'(rec_b_addr[15][3:0]), 64'd15);
    check_eq("k16 a_addr3 t18", 64'(rec_a_addr[18][15:12]), 64'd15);
    check_eq("k16 done t23", 64'(rec_done[23]), 64'd1);

    // start held: one idle cycle after done, then the next pass begins at t=0
    run_pass(2, 1'b1);
    @(negedge clk);
    check_eq("hold busy restart", 64'(busy), 64'd1);
    check_eq("hold a_valid restart", 64'(a_valid), 64'h1);
    check_eq("hold a_addr restart", 64'(a_addr), 64'h0);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("hold done pass2", 64'(done), 64'd1);
    @(negedge clk);

    // illegal depths are ignored
    start = 1'b1;
    k_len = 5'd0;
    @(negedge clk);
    k_len = 5'd17;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq($sformatf("badk c%0d busy", c), 64'(busy), 64'd0);
      check_eq($sformatf("badk c%0d done", c), 64'(done), 64'd0);
      check_eq($sformatf("badk c%0d finish", c), 64'(finish), 64'd0);
      @(negedge clk);
    end

    // reset aborts a K=4 pass at t=5
    start = 1'b1;
    k_len = 5'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("abort a_valid t5", 64'(a_valid), 64'hC);
    check_eq("abort a_addr t5", 64'(a_addr), 64'h2300);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort busy", 64'(busy), 64'd0);
    check_eq("abort a_valid", 64'(a_valid), 64'd0);
    check_eq("abort a_addr", 64'(a_addr), 64'd0);
    check_eq("abort b_valid", 64'(b_valid), 64'd0);
    check_eq("abort finish", 64'(finish), 64'd0);
    for (int c = 0; c < 10; c++) begin
      check_eq($sformatf("abort c%0d done", c), 64'(done), 64'd0);
      check_eq($sformatf("abort c%0d busy", c), 64'(busy), 64'd0);
      @(negedge clk);
    end
    run_pass(4, 1'b0);
    check_eq("post-abort done t11", 64'(rec_done[11]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
